// File: rtl/mac_acc_array_if.sv
// Beat/result bundle between the operand buffers, the MAC array and post-processing.
// The driver owns the beat fields and the MAC array owns the group result fields.
interface mac_acc_array_if #(
  parameter int LANES = 16,
  parameter int DW    = 8,
  parameter int ACCW  = 32
);
  logic                  vld_i;
  logic                  first_i;
  logic                  last_i;
  logic                  sgn_i;
  logic [LANES*DW-1:0]   win;
  logic [LANES*DW-1:0]   din;
  logic [ACCW-1:0]       acc_o;
  logic                  sat_o;
  logic                  vld_o;

  modport master (
    output vld_i, first_i, last_i, sgn_i, win, din,
    input  acc_o, sat_o, vld_o
  );

  modport slave (
    input  vld_i, first_i, last_i, sgn_i, win, din,
    output acc_o, sat_o, vld_o
  );
endinterface

// File: rtl/mac_acc_array.sv
// LANES-wide dot-product MAC: registered products, pipelined adder tree, then a
// framed saturating accumulator that emits one result pulse per group.
module mac_acc_array #(
  parameter int LANES = 16,
  parameter int DW    = 8,
  parameter int ACCW  = 32
) (
  input  logic             clk,
  input  logic             rstn,
  mac_acc_array_if.slave   bus
);
  localparam int L     = $clog2(LANES);
  localparam int PW    = 2 * DW;
  localparam int SW    = PW + L;
  localparam int XW    = ACCW + 2;
  localparam int NODES = 2 * LANES - 1;

  localparam logic [XW-1:0] S_MAX = {3'b000, {(ACCW-1){1'b1}}};
  localparam logic [XW-1:0] S_MIN = {3'b111, {(ACCW-1){1'b0}}};
  localparam logic [XW-1:0] U_MAX = {2'b00, {ACCW{1'b1}}};

  // Heap-ordered tree: node i has children 2i+1 and 2i+2; leaves start at LANES-1.
  logic [SW-1:0] node [NODES];
  logic [SW-1:0] leaf_c [LANES];

  logic [L:0] vld_p;
  logic [L:0] first_p;
  logic [L:0] last_p;
  logic [L:0] sgn_p;

  logic [ACCW-1:0] acc_q;
  logic            sticky_q;
  logic [ACCW-1:0] acc_out_q;
  logic            sat_out_q;
  logic            vld_out_q;

  logic [XW-1:0]   s_ext;
  logic [XW-1:0]   acc_ext;
  logic [XW-1:0]   sum;
  logic [ACCW-1:0] acc_next;
  logic            clamp;
  logic            sticky_base;

  logic sgn_a;
  logic first_a;
  assign sgn_a   = sgn_p[L];
  assign first_a = first_p[L];

  // Operands are extended to product width so the low PW bits are the exact product in either mode.
  always_comb begin : mult_c
    logic [PW-1:0] w_ext;
    logic [PW-1:0] x_ext;
    logic [PW-1:0] prod;
    w_ext = '0;
    x_ext = '0;
    prod  = '0;
    for (int k = 0; k < LANES; k++) begin
      w_ext     = {{DW{bus.sgn_i & bus.win[k*DW+DW-1]}}, bus.win[k*DW +: DW]};
      x_ext     = {{DW{bus.sgn_i & bus.din[k*DW+DW-1]}}, bus.din[k*DW +: DW]};
      prod      = w_ext * x_ext;
      leaf_c[k] = {{L{bus.sgn_i & prod[PW-1]}}, prod};
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      node[LANES-1+k] <= leaf_c[k];
    end
    for (int i = 0; i < LANES - 1; i++) begin
      node[i] <= node[2*i+1] + node[2*i+2];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_p   <= '0;
      first_p <= '0;
      last_p  <= '0;
      sgn_p   <= '0;
    end else begin
      vld_p   <= {vld_p[L-1:0],   bus.vld_i};
      first_p <= {first_p[L-1:0], bus.first_i};
      last_p  <= {last_p[L-1:0],  bus.last_i};
      sgn_p   <= {sgn_p[L-1:0],   bus.sgn_i};
    end
  end

  // Two guard bits let the raw sum exceed the ACCW range in both modes before clamping.
  always_comb begin
    s_ext       = {{(XW-SW){sgn_a & node[0][SW-1]}}, node[0]};
    acc_ext     = first_a ? '0 : {{2{sgn_a & acc_q[ACCW-1]}}, acc_q};
    sum         = acc_ext + s_ext;
    sticky_base = first_a ? 1'b0 : sticky_q;
    clamp       = 1'b0;
    acc_next    = sum[ACCW-1:0];
    if (sgn_a) begin
      if ($signed(sum) > $signed(S_MAX)) begin
        clamp    = 1'b1;
        acc_next = {1'b0, {(ACCW-1){1'b1}}};
      end else if ($signed(sum) < $signed(S_MIN)) begin
        clamp    = 1'b1;
        acc_next = {1'b1, {(ACCW-1){1'b0}}};
      end
    end else if (sum > U_MAX) begin
      clamp    = 1'b1;
      acc_next = {ACCW{1'b1}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_q     <= '0;
      sticky_q  <= 1'b0;
      acc_out_q <= '0;
      sat_out_q <= 1'b0;
      vld_out_q <= 1'b0;
    end else begin
      vld_out_q <= 1'b0;
      if (vld_p[L]) begin
        if (last_p[L]) begin
          acc_out_q <= acc_next;
          sat_out_q <= sticky_base | clamp;
          vld_out_q <= 1'b1;
          acc_q     <= '0;
          sticky_q  <= 1'b0;
        end else begin
          acc_q     <= acc_next;
          sticky_q  <= sticky_base | clamp;
        end
      end
    end
  end

  assign bus.acc_o = acc_out_q;
  assign bus.sat_o = sat_out_q;
  assign bus.vld_o = vld_out_q;

endmodule

// File: doc/mac_acc_array.md
Name: mac_acc_array

Overview:
- Parametrised successor to the fixed 16-lane 8-bit MAC.
- Computes a LANES-wide dot product per beat: registered multipliers feed a fully pipelined adder tree.
- Adds a multi-beat accumulator framed by first/last flags, per-beat signed/unsigned mode, and saturation.
- Sits between the operand buffers and the post-processing (quantise/activation) stage of the conv engine.

Parameters:
- LANES, 16, number of multiplier lanes; power of two, >= 2.
- DW, 8, operand width per lane (weight and data).
- ACCW, 32, accumulator and output width; must be >= 2*DW + clog2(LANES).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; synchronous, active-low.
- vld_i  in  1  beat valid.
- first_i  in  1  first beat of an accumulation group; qualified by vld_i.
- last_i  in  1  last beat of the group; qualified by vld_i.
- sgn_i  in  1  1 = operands two's complement, 0 = unsigned; qualified by vld_i.
- win  in  LANES*DW  weights; lane k at bits [k*DW +: DW].
- din  in  LANES*DW  activations; same packing as win.
- acc_o  out  ACCW  group result; sign-extended in signed mode, zero-extended in unsigned mode.
- sat_o  out  1  group saturated at least once; valid with vld_o.
- vld_o  out  1  one-cycle pulse; acc_o and sat_o are valid.

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous, active-low.
- Reset clears all pipeline valids, sideband, accumulator and sticky flag. acc_o=0, sat_o=0, vld_o=0.
- Reset mid-group discards all in-flight beats. No output is produced for the interrupted group.
- No backpressure. A beat is accepted on every cycle with vld_i=1.
- vld_i=0 cycles are bubbles. first_i, last_i, sgn_i, win and din are ignored on those cycles.
- Pipeline, L = clog2(LANES):
  - Stage M: LANES registered products, 2*DW bits each. Signed or unsigned per that beat's sgn_i.
  - Stages T1..TL: one registered adder-tree level each. Operands are sign- or zero-extended per beat mode. Sum width is 2*DW+L.
  - Stage A: accumulator update.
- vld, first, last and sgn travel alongside the data through every stage.
- Latency: a beat with last_i=1 accepted at cycle t gives vld_o=1 at cycle t+L+2. Default config: t+6.
- Accumulator at stage A, for a valid beat with sum s:
  - If first: acc_next = s.
  - Else: acc_next = acc + s.
  - Result is saturated to the ACCW range: signed [-2^(ACCW-1), 2^(ACCW-1)-1], unsigned [0, 2^ACCW-1].
  - On clamp, the sticky flag is set. first clears the sticky flag before the beat is evaluated.
- On a last beat:
  - acc_o <= acc_next, sat_o <= sticky|clamp, vld_o=1 for one cycle.
  - Internal acc and sticky are then cleared to 0.
- first and last on the same beat form a single-beat group. Result = s.
- A beat without first after a completed group accumulates onto 0.
- first arriving mid-group restarts the group. Prior partial sum and sticky flag are discarded.
- acc_o and sat_o hold their last value until the next vld_o. vld_o is never asserted without last.
- The mode of a group is taken from each beat's sgn_i. Mixing modes within a group is illegal; the result is undefined but the block must not hang.
- Back-to-back groups (last at t, first at t+1) are supported at full throughput.

Test Plan:
- Default config, unsigned, all lanes w=2 x=3, one beat first=last=1 -> vld_o exactly 6 cycles later, acc_o=96, sat_o=0.
- Signed, all lanes w=-128 x=-128, single beat -> acc_o=262144. Then all lanes w=-128 x=127, single beat -> acc_o=-260096 (0xFFFC_0800).
- 4-beat unsigned group, all lanes w=1 x=1, bubbles between beats 2 and 3 -> exactly one vld_o, 6 cycles after the last beat, acc_o=64.
- ACCW=20 signed, three beats of all lanes w=-128 x=-128 (262144 each) -> acc_o=524287, sat_o=1. Next single-beat group w=1 x=1 -> acc_o=16, sat_o=0.
- Back-to-back groups: G1 = 2 beats of 16 -> 32. G2, starting the cycle after G1's last, = 1 beat of 48 -> two vld_o pulses one cycle apart, acc_o=32 then 48.
- Assert rstn=0 for one cycle mid-group, then send a single-beat group with sum 5 -> no output for the aborted group. Outputs stay 0 until a pulse with acc_o=5.
